// File: rtl/dcache_mem_arbiter.sv
// Round-robin arbiter multiplexing dcache fill/eviction requests onto a set of
// memory channels, each running its own request/relay state machine.
module dcache_mem_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [ADDR_BITS*NUM_CONSUMERS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [DATA_BITS*NUM_CONSUMERS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [ADDR_BITS*NUM_CONSUMERS-1:0] consumer_write_address,
    input  logic [DATA_BITS*NUM_CONSUMERS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [ADDR_BITS*NUM_CHANNELS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [DATA_BITS*NUM_CHANNELS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]            mem_write_valid,
    output logic [ADDR_BITS*NUM_CHANNELS-1:0]  mem_write_address,
    output logic [DATA_BITS*NUM_CHANNELS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

    localparam int unsigned NC = NUM_CONSUMERS;
    localparam int PW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ_WAIT,
        WRITE_WAIT,
        READ_RELAY,
        WRITE_RELAY
    } state_t;

    state_t          state [NUM_CHANNELS];
    logic [PW-1:0]   current_consumer [NUM_CHANNELS];
    logic [NC-1:0]   busy;
    logic [PW-1:0]   rr_ptr;

    logic [NUM_CHANNELS-1:0] gnt;
    logic [NUM_CHANNELS-1:0] gnt_write;
    logic [PW-1:0]           gnt_idx [NUM_CHANNELS];
    logic [PW-1:0]           next_ptr;
    logic [NC-1:0]           taken;
    int unsigned             ptr;
    int unsigned             idx;

    // Each idle channel continues the scan just past the previous channel's grant,
    // so one cycle hands out distinct consumers in round-robin order.
    always_comb begin
        taken = busy;
        ptr   = 32'(rr_ptr);
        idx   = 0;
        for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            gnt[ch]       = 1'b0;
            gnt_write[ch] = 1'b0;
            gnt_idx[ch]   = '0;
            if (state[ch] == IDLE) begin
                for (int unsigned k = 0; k < NC; k++) begin
                    idx = (ptr + k) % NC;
                    if (!gnt[ch] && !taken[idx] &&
                        (consumer_read_valid[idx] || consumer_write_valid[idx])) begin
                        gnt[ch]       = 1'b1;
                        gnt_idx[ch]   = PW'(idx);
                        gnt_write[ch] = consumer_write_valid[idx];
                        taken[idx]    = 1'b1;
                    end
                end
                if (gnt[ch]) begin
                    ptr = (32'(gnt_idx[ch]) + 1) % NC;
                end
            end
        end
        next_ptr = PW'(ptr);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy                 <= '0;
            rr_ptr               <= '0;
            consumer_read_ready  <= '0;
            consumer_read_data   <= '0;
            consumer_write_ready <= '0;
            mem_read_valid       <= '0;
            mem_read_address     <= '0;
            mem_write_valid      <= '0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
            for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
                state[ch]            <= IDLE;
                current_consumer[ch] <= '0;
            end
        end else begin
            rr_ptr <= next_ptr;
            for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
                case (state[ch])
                    IDLE: begin
                        if (gnt[ch]) begin
                            current_consumer[ch] <= gnt_idx[ch];
                            busy[gnt_idx[ch]]    <= 1'b1;
                            // Eviction goes first when a consumer asks for both.
                            if (gnt_write[ch]) begin
                                mem_write_valid[ch] <= 1'b1;
                                mem_write_address[ch*ADDR_BITS +: ADDR_BITS] <=
                                    consumer_write_address[gnt_idx[ch]*ADDR_BITS +: ADDR_BITS];
                                mem_write_data[ch*DATA_BITS +: DATA_BITS] <=
                                    consumer_write_data[gnt_idx[ch]*DATA_BITS +: DATA_BITS];
                                state[ch] <= WRITE_WAIT;
                            end else begin
                                mem_read_valid[ch] <= 1'b1;
                                mem_read_address[ch*ADDR_BITS +: ADDR_BITS] <=
                                    consumer_read_address[gnt_idx[ch]*ADDR_BITS +: ADDR_BITS];
                                state[ch] <= READ_WAIT;
                            end
                        end
                    end
                    READ_WAIT: begin
                        if (mem_read_ready[ch]) begin
                            mem_read_valid[ch] <= 1'b0;
                            consumer_read_data[current_consumer[ch]*DATA_BITS +: DATA_BITS] <=
                                mem_read_data[ch*DATA_BITS +: DATA_BITS];
                            consumer_read_ready[current_consumer[ch]] <= 1'b1;
                            state[ch] <= READ_RELAY;
                        end
                    end
                    WRITE_WAIT: begin
                        if (mem_write_ready[ch]) begin
                            mem_write_valid[ch] <= 1'b0;
                            consumer_write_ready[current_consumer[ch]] <= 1'b1;
                            state[ch] <= WRITE_RELAY;
                        end
                    end
                    READ_RELAY: begin
                        if (!consumer_read_valid[current_consumer[ch]]) begin
                            consumer_read_ready[current_consumer[ch]] <= 1'b0;
                            busy[current_consumer[ch]] <= 1'b0;
                            state[ch] <= IDLE;
                        end
                    end
                    WRITE_RELAY: begin
                        if (!consumer_write_valid[current_consumer[ch]]) begin
                            consumer_write_ready[current_consumer[ch]] <= 1'b0;
                            busy[current_consumer[ch]] <= 1'b0;
                            state[ch] <= IDLE;
                        end
                    end
                    default: state[ch] <= IDLE;
                endcase
            end
        end
    end

endmodule
